// File: rtl/pla_bench_pkg.sv
// Shared types and helpers for the PLA exhaustive stimulus/response driver.
// Holds the sequencer state encoding and the signature next-state function.
package pla_bench_pkg;

  localparam int          SIG_W_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } pla_state_e;

  // One shift of the serial-input signature register at the default width.
  function automatic logic [SIG_W_DEF-1:0] sig_next(
    input logic [SIG_W_DEF-1:0] sig,
    input logic                 bit_in,
    input logic [SIG_W_DEF-1:0] poly
  );
    logic fb;
    fb = sig[SIG_W_DEF-1] ^ bit_in;
    return {sig[SIG_W_DEF-2:0], 1'b0} ^ (poly & {SIG_W_DEF{fb}});
  endfunction

endpackage

// File: rtl/pla_sig_misr.sv
// Serial-input signature register: compacts one response bit per enabled cycle.
// Clear has priority over enable so a new run always starts from zero.
module pla_sig_misr
  import pla_bench_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_r;
  logic             fb_s;

  // Feedback tap mixes the outgoing MSB with the incoming response bit.
  always_comb begin
    fb_s = sig_r[SIG_W-1] ^ bit_in;
  end

  // Signature state: clear on run start, shift on each sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= {SIG_W{1'b0}};
    end else if (clr) begin
      sig_r <= {SIG_W{1'b0}};
    end else if (en) begin
      sig_r <= {sig_r[SIG_W-2:0], 1'b0} ^ (POLY & {SIG_W{fb_s}});
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/pla_exhaustive_driver.sv
// Exhaustive driver for a single-output N_IN-input combinational function:
// walks every input vector, samples y_in after a settle window and compacts results.
module pla_exhaustive_driver
  import pla_bench_pkg::*;
#(
  parameter int               N_IN   = 8,
  parameter int               SETTLE = 2,
  parameter int               SIG_W  = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     ones_count,
  output logic              first_one_valid,
  output logic [N_IN-1:0]   first_one,
  output logic [SIG_W-1:0]  signature
);

  localparam int HOLD_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE - 1);

  pla_state_e        state_r;
  logic [N_IN-1:0]   vec_r;
  logic [HOLD_W-1:0] hold_r;
  logic              busy_r;
  logic              done_r;
  logic [N_IN:0]     ones_r;
  logic              first_valid_r;
  logic [N_IN-1:0]   first_r;

  logic              accept_s;
  logic              sample_s;
  logic              last_vec_s;

  // Decode run start and the sample edge; abort suppresses sampling while busy.
  always_comb begin
    accept_s   = 1'b0;
    sample_s   = 1'b0;
    last_vec_s = (vec_r == {N_IN{1'b1}});
    case (state_r)
      ST_IDLE, ST_DONE: accept_s = start;
      ST_HOLD:          sample_s = (hold_r == HOLD_LAST) && !abort;
      ST_LAST:          sample_s = 1'b0;
      default:          sample_s = 1'b0;
    endcase
  end

  // Sequencer, vector/hold counters and the count/first-minterm results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      vec_r         <= {N_IN{1'b0}};
      hold_r        <= {HOLD_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      ones_r        <= {(N_IN+1){1'b0}};
      first_valid_r <= 1'b0;
      first_r       <= {N_IN{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            state_r       <= ST_HOLD;
            vec_r         <= {N_IN{1'b0}};
            hold_r        <= {HOLD_W{1'b0}};
            busy_r        <= 1'b1;
            ones_r        <= {(N_IN+1){1'b0}};
            first_valid_r <= 1'b0;
            first_r       <= {N_IN{1'b0}};
          end else begin
            state_r <= state_r;
          end
        end
        ST_HOLD: begin
          if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (sample_s) begin
            ones_r <= ones_r + {{N_IN{1'b0}}, y_in};
            if (y_in && !first_valid_r) begin
              first_r       <= vec_r;
              first_valid_r <= 1'b1;
            end else begin
              first_r       <= first_r;
            end
            // Leave on the final vector before any increment so vec never wraps.
            if (last_vec_s) begin
              state_r <= ST_LAST;
            end else begin
              vec_r  <= vec_r + {{(N_IN-1){1'b0}}, 1'b1};
              hold_r <= {HOLD_W{1'b0}};
            end
          end else begin
            hold_r <= hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        ST_LAST: begin
          busy_r <= 1'b0;
          if (abort) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  pla_sig_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept_s),
    .en     (sample_s),
    .bit_in (y_in),
    .sig    (signature)
  );

  assign x_out           = vec_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign ones_count      = ones_r;
  assign first_one_valid = first_valid_r;
  assign first_one       = first_r;

endmodule

// File: tb/tb_pla_exhaustive_driver.sv
// Directed bench for pla_exhaustive_driver: drives several fixed functions on y_in
// and checks latency, done pulse, counts, first minterm and signature.
module tb_pla_exhaustive_driver;
  import pla_bench_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  x_out;
  logic        y_in;
  logic        busy;
  logic        done;
  logic [8:0]  ones_count;
  logic        first_one_valid;
  logic [7:0]  first_one;
  logic [15:0] signature;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int lat;
  int ndone;
  bit found;

  pla_exhaustive_driver dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .x_out           (x_out),
    .y_in            (y_in),
    .busy            (busy),
    .done            (done),
    .ones_count      (ones_count),
    .first_one_valid (first_one_valid),
    .first_one       (first_one),
    .signature       (signature)
  );

  always #5 clk = ~clk;

  function automatic logic fut(input int m, input logic [7:0] v);
    case (m)
      1:       return v[0];
      2:       return (v == 8'hFF);
      3:       return 1'b1;
      4:       return v[7];
      default: return 1'b0;
    endcase
  endfunction

  always_comb y_in = fut(mode, x_out);

  function automatic logic [15:0] model_sig(input int m);
    logic [15:0] s;
    s = 16'h0000;
    for (int v = 0; v < 256; v++) s = sig_next(s, fut(m, 8'(v)), POLY_DEF);
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a run, then watch 700 cycles; optional abort / ignored start at given cycle.
  task automatic do_run(input int abort_at, input int restart_at, output int l, output int nd);
    l  = -1;
    nd = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    check("vec0_after_start", {24'd0, x_out}, 32'h00);
    check("busy_after_start", {31'd0, busy}, 32'h1);
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      abort = (k == abort_at);
      start = (k == restart_at);
      @(posedge clk) #1;
      abort = 1'b0;
      start = 1'b0;
      if (k == abort_at) check("busy_after_abort", {31'd0, busy}, 32'h0);
      if (done) begin
        nd++;
        if (l < 0) l = k;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_done", {31'd0, done}, 32'h0);
    check("rst_x_out", {24'd0, x_out}, 32'h0);
    check("rst_sig", {16'd0, signature}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant-0 function.
    mode = 0;
    do_run(0, 0, lat, ndone);
    check("c0_latency", lat, 513);
    check("c0_ndone", ndone, 1);
    check("c0_ones", {23'd0, ones_count}, 32'h0);
    check("c0_valid", {31'd0, first_one_valid}, 32'h0);
    check("c0_sig", {16'd0, signature}, 32'h0000);
    check("c0_x_held", {24'd0, x_out}, 32'hFF);
    check("c0_busy", {31'd0, busy}, 32'h0);

    // y = x0.
    mode = 1;
    do_run(0, 0, lat, ndone);
    check("x0_latency", lat, 513);
    check("x0_ones", {23'd0, ones_count}, 32'd128);
    check("x0_first", {24'd0, first_one}, 32'h01);
    check("x0_valid", {31'd0, first_one_valid}, 32'h1);
    check("x0_sig", {16'd0, signature}, {16'd0, model_sig(1)});

    // Single minterm at all-ones.
    mode = 2;
    do_run(0, 0, lat, ndone);
    check("ff_ndone", ndone, 1);
    check("ff_ones", {23'd0, ones_count}, 32'd1);
    check("ff_first", {24'd0, first_one}, 32'hFF);
    check("ff_valid", {31'd0, first_one_valid}, 32'h1);
    check("ff_sig", {16'd0, signature}, {16'd0, model_sig(2)});

    // Constant-1: count reaches 256 without wrap.
    mode = 3;
    do_run(0, 0, lat, ndone);
    check("c1_ones", {23'd0, ones_count}, 32'h100);
    check("c1_first", {24'd0, first_one}, 32'h00);
    check("c1_sig", {16'd0, signature}, {16'd0, model_sig(3)});

    // Abort at cycle 100, then a full run with y = x7.
    mode = 4;
    do_run(100, 0, lat, ndone);
    check("abort_ndone", ndone, 0);
    do_run(0, 0, lat, ndone);
    check("x7_latency", lat, 513);
    check("x7_ones", {23'd0, ones_count}, 32'd128);
    check("x7_first", {24'd0, first_one}, 32'h80);
    check("x7_sig", {16'd0, signature}, {16'd0, model_sig(4)});

    // Asynchronous reset mid-run when vec reaches 8'h40.
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(posedge clk) #1;
      if (x_out == 8'h40) found = 1'b1;
    end
    check("reach_vec40", {31'd0, found}, 32'h1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mrst_x_out", {24'd0, x_out}, 32'h0);
    check("mrst_busy", {31'd0, busy}, 32'h0);
    check("mrst_done", {31'd0, done}, 32'h0);
    check("mrst_ones", {23'd0, ones_count}, 32'h0);
    check("mrst_valid", {31'd0, first_one_valid}, 32'h0);
    check("mrst_first", {24'd0, first_one}, 32'h0);
    check("mrst_sig", {16'd0, signature}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Start pulse while busy is ignored.
    mode = 3;
    do_run(0, 50, lat, ndone);
    check("ign_latency", lat, 513);
    check("ign_ndone", ndone, 1);
    check("ign_ones", {23'd0, ones_count}, 32'h100);
    check("ign_first", {24'd0, first_one}, 32'h00);
    check("ign_sig", {16'd0, signature}, {16'd0, model_sig(3)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pla_exhaustive_driver.md
Name: pla_exhaustive_driver

Overview:
- Sequential stimulus/response end for the single-output combinational PLA benchmark blocks (8 inputs x0..x7, output y0).
- Enumerates every input vector, drives it to the function under test, samples the returned output bit and compacts the responses.
- Results: count of ones, first minterm, CRC-style signature. Used to compare optimised netlists against their originals on-chip.

Parameters:
- N_IN, 8, number of function inputs; vectors 0..2^N_IN-1.
- SETTLE, 2, cycles each vector is held (>=1); y_in sampled at the last edge of the window.
- SIG_W, 16, signature width.
- POLY, 16'h1021, feedback polynomial of the signature register.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin run; accepted only when not busy
- abort  in  1  cancel a run in progress
- x_out  out  N_IN  vector driven to the function under test (bit i -> xi)
- y_in  in  1  function output y0
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when a run completes
- ones_count  out  N_IN+1  number of vectors with y_in=1
- first_one_valid  out  1  at least one minterm found
- first_one  out  N_IN  lowest vector with y_in=1
- signature  out  SIG_W  response compaction register

Behaviour:
- Reset: every output and internal register is 0, and the FSM is in IDLE. Reset is asynchronous and active-low and aborts any run immediately.
- FSM states: IDLE, HOLD, LAST, DONE.
- IDLE, start=1:
  - vec<=0; hold counter<=0; ones_count, first_one, first_one_valid and signature cleared.
  - busy<=1; go to HOLD.
  - x_out follows vec combinationally from the register, so vector 0 appears on the cycle after start.
- HOLD: hold counter increments each cycle. When it reaches SETTLE-1, that edge is the sample edge:
  - ones_count += y_in.
  - If y_in=1 and !first_one_valid: first_one<=vec and first_one_valid<=1.
  - signature <= {signature[SIG_W-2:0],1'b0} ^ (POLY & {SIG_W{signature[SIG_W-1]^y_in}}).
  - If vec == 2^N_IN-1, go to LAST. Otherwise vec increments and the hold counter clears.
- LAST: busy<=0; done<=1 for exactly one cycle; go to DONE.
- DONE: results and x_out (all-ones vector) are held stable. A new start clears the results and re-enters HOLD (same actions as from IDLE).
- Latency: done rises exactly 2^N_IN*SETTLE+1 cycles after the start-accept edge.
  - N_IN=8, SETTLE=2: 513 cycles.
- start while busy: ignored.
- abort while busy: go to IDLE the next edge; busy<=0; no done. Results keep partial values but are undefined to the consumer. abort outside busy has no effect.
- start and abort in the same cycle:
  - From IDLE/DONE, start wins.
  - While busy, abort wins.
- Width rules:
  - ones_count is N_IN+1 bits, so all-ones reaches exactly 2^N_IN without wrap.
  - vec must not wrap past the final vector; the LAST transition happens before any increment.
- y_in is treated as synchronous to clk. The function under test is combinational with a path shorter than SETTLE cycles.

Decomposition:
- Shared package pla_bench_pkg holds:
  - the FSM state enum (IDLE/HOLD/LAST/DONE);
  - the default POLY and SIG_W constants;
  - a function computing the signature next state, reused by the checker model.
- One natural sub-module: pla_sig_misr (serial-input signature register with clear and enable). All other logic is flat.

Test Plan:
- Constant-0 function, SETTLE=2, start pulse -> done 513 cycles later; ones_count=0; first_one_valid=0; signature=16'h0000; x_out=8'hFF held.
- y_in=x_out[0] -> ones_count=128; first_one=8'h01; signature equals package-function model over the 256 responses.
- y_in=(x_out==8'hFF) -> ones_count=1; first_one=8'hFF; first_one_valid=1; done exactly one cycle.
- Constant-1 function -> ones_count=256 (9'h100, no wrap); first_one=8'h00; signature matches model.
- abort at cycle 100 of a run, then start again with y_in=x_out[7] -> no done for the aborted run; second run gives ones_count=128 and first_one=8'h80.
- rst_n low for one cycle mid-run at vec=8'h40, then start ignored while busy in a later run -> all outputs 0 immediately on reset; the later run completes once with correct counts.
